// File: rtl/ksa.sv
// ---------------------------------------------------------------------------
// ksa -- RC4 key-scheduling stage.
//
// Runs the RC4 key-scheduling recurrence over a 256x8 S array that already
// holds the identity permutation. The S array lives in a shared single-port
// memory with a registered address: read data appears one cycle after the
// address is presented. Each of the 256 iterations takes six cycles:
//   RD_I -> LD_I -> RD_J -> LD_J -> WR_I -> WR_J
// which is 1536 busy cycles per run and 512 writes.
//
// Handshake: rdy is high only in IDLE. A request is accepted on a rising
// edge where en = 1 and rdy = 1. rdy drops in the following cycle and stays
// low until the run completes. en while busy is ignored (not queued). rst
// takes priority over en.
//
// Parameters:
//   KEYLEN  key length in bytes (1..8)
//
// Ports:
//   clk     in   1          clock, rising edge
//   rst     in   1          synchronous active-high reset
//   en      in   1          start request
//   rdy     out  1          idle and able to accept en
//   key     in   8*KEYLEN   key, byte 0 is the most significant byte
//   addr    out  8          S memory address
//   rddata  in   8          S memory read data (valid one cycle after addr)
//   wrdata  out  8          S memory write data
//   wren    out  1          S memory write enable
// ---------------------------------------------------------------------------
module ksa #(
  parameter int KEYLEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rdy,
  input  logic [8*KEYLEN-1:0]   key,
  output logic [7:0]            addr,
  input  logic [7:0]            rddata,
  output logic [7:0]            wrdata,
  output logic                  wren
);

  // Key index width; a 1-byte key still gets a 1-bit counter that stays 0.
  localparam int KW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    LD_I,
    RD_J,
    LD_J,
    WR_I,
    WR_J
  } state_t;

  state_t              state;
  logic [7:0]          i;
  logic [7:0]          j;
  logic [KW-1:0]       kidx;
  logic [7:0]          si;
  logic [7:0]          sj;
  logic [8*KEYLEN-1:0] key_q;

  logic [7:0]          key_byte;
  logic [7:0]          j_next;

  // Select the current key byte with a plain mux over the latched key.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEYLEN; k++) begin
      if (kidx == KW'(k)) begin
        key_byte = key_q[8*(KEYLEN-k)-1 -: 8];
      end
    end
  end

  // j update uses rddata in LD_I; the result only reaches addr through a
  // register, so there is no combinational rddata -> addr path.
  assign j_next = j + rddata + key_byte;

  // All outputs are registered: the value loaded on a transition is what the
  // memory sees while the FSM sits in the destination state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      kidx   <= '0;
      si     <= '0;
      sj     <= '0;
      key_q  <= '0;
      rdy    <= 1'b1;
      addr   <= '0;
      wrdata <= '0;
      wren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            i      <= '0;
            j      <= '0;
            kidx   <= '0;
            key_q  <= key;
            rdy    <= 1'b0;
            addr   <= '0;        // RD_I presents i = 0
            wrdata <= '0;
            wren   <= 1'b0;
            state  <= RD_I;
          end
        end

        RD_I: begin
          state <= LD_I;
        end

        LD_I: begin
          si    <= rddata;
          j     <= j_next;
          addr  <= j_next;       // RD_J presents the updated j
          state <= RD_J;
        end

        RD_J: begin
          state <= LD_J;
        end

        LD_J: begin
          sj     <= rddata;
          addr   <= i;
          wrdata <= rddata;      // WR_I writes old s[j] to s[i]
          wren   <= 1'b1;
          state  <= WR_I;
        end

        WR_I: begin
          addr   <= j;
          wrdata <= si;          // WR_J writes old s[i] to s[j]
          wren   <= 1'b1;
          state  <= WR_J;
        end

        WR_J: begin
          wren   <= 1'b0;
          wrdata <= '0;
          if (i == 8'hFF) begin
            rdy   <= 1'b1;
            addr  <= '0;
            state <= IDLE;
          end else begin
            i     <= i + 8'd1;
            addr  <= i + 8'd1;
            if (kidx == KW'(KEYLEN-1)) begin
              kidx <= '0;
            end else begin
              kidx <= kidx + KW'(1);
            end
            state <= RD_I;
          end
        end

        default: begin
          rdy    <= 1'b1;
          addr   <= '0;
          wrdata <= '0;
          wren   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// ---------------------------------------------------------------------------
// tb_ksa -- bench for the RC4 key-scheduling stage.
//
// Two instances: u_ksa0 with a 3-byte key and u_ksa1 with a 1-byte key, each
// attached to its own registered-address 256x8 memory model. A software KSA
// model fills an expected write queue per instance; a monitor pops it on
// every write. Final S contents are compared against the model array.
// ---------------------------------------------------------------------------
module tb_ksa;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, en0, rdy0, wren0;
  logic [23:0] key0;
  logic [7:0]  addr0, rddata0, wrdata0;

  logic        rst1, en1, rdy1, wren1;
  logic [7:0]  key1;
  logic [7:0]  addr1, rddata1, wrdata1;

  ksa #(.KEYLEN(3)) u_ksa0 (
    .clk    (clk),
    .rst    (rst0),
    .en     (en0),
    .rdy    (rdy0),
    .key    (key0),
    .addr   (addr0),
    .rddata (rddata0),
    .wrdata (wrdata0),
    .wren   (wren0)
  );

  ksa #(.KEYLEN(1)) u_ksa1 (
    .clk    (clk),
    .rst    (rst1),
    .en     (en1),
    .rdy    (rdy1),
    .key    (key1),
    .addr   (addr1),
    .rddata (rddata1),
    .wrdata (wrdata1),
    .wren   (wren1)
  );

  // ---------------- memory models ----------------
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       init0, init1;

  always @(posedge clk) begin
    if (init0) begin
      for (int k = 0; k < 256; k++) mem0[k] <= 8'(k);
    end else if (wren0 === 1'b1) begin
      mem0[addr0] <= wrdata0;
    end
    rddata0 <= mem0[addr0];
  end

  always @(posedge clk) begin
    if (init1) begin
      for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
    end else if (wren1 === 1'b1) begin
      mem1[addr1] <= wrdata1;
    end
    rddata1 <= mem1[addr1];
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] log0[$];
  logic [15:0] log1[$];
  logic [7:0]  ms [256];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] got0, want0, got1, want1;

  always @(negedge clk) begin
    if (wren0 === 1'b1) begin
      got0 = {addr0, wrdata0};
      log0.push_back(got0);
      if (exp_q0.size() != 0) want0 = exp_q0.pop_front();
      else want0 = 16'hxxxx;
      chk($sformatf("wr0_%0d", log0.size() - 1), {16'h0, got0}, {16'h0, want0});
    end
  end

  always @(negedge clk) begin
    if (wren1 === 1'b1) begin
      got1 = {addr1, wrdata1};
      log1.push_back(got1);
      if (exp_q1.size() != 0) want1 = exp_q1.pop_front();
      else want1 = 16'hxxxx;
      chk($sformatf("wr1_%0d", log1.size() - 1), {16'h0, got1}, {16'h0, want1});
    end
  end

  // ---------------- model ----------------
  task automatic model_init();
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
  endtask

  // Standard RC4 KSA over ms[], pushing the expected (addr, data) write pairs.
  task automatic model_run(input logic [63:0] key, input int keylen, input int which);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    int         kb_base;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb_base = 8 * (keylen - (i % keylen)) - 1;
      kb = key[kb_base -: 8];
      j = j + ms[i] + kb;
      t = ms[i];
      if (which == 0) begin
        exp_q0.push_back({8'(i), ms[j]});
        exp_q0.push_back({j, t});
      end else begin
        exp_q1.push_back({8'(i), ms[j]});
        exp_q1.push_back({j, t});
      end
      ms[i] = ms[j];
      ms[j] = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_init(input int which);
    @(negedge clk);
    if (which == 0) init0 = 1'b1;
    else init1 = 1'b1;
    @(negedge clk);
    init0 = 1'b0;
    init1 = 1'b0;
  endtask

  task automatic start(input int which, input string tag);
    @(negedge clk);
    if (which == 0) begin
      chk({tag, "_rdy_before"}, {31'h0, rdy0}, 32'd1);
      en0 = 1'b1;
    end else begin
      chk({tag, "_rdy_before"}, {31'h0, rdy1}, 32'd1);
      en1 = 1'b1;
    end
  endtask

  // Counts cycles after the accepting edge until rdy is seen high (bounded).
  // p1/p2: cycles to pulse en while busy; kc: cycle to disturb key0;
  // chain: hold en high in the first rdy cycle for a back-to-back run.
  task automatic run_wait(input int which, input int p1, input int p2, input int kc,
                          input logic chain, output int n);
    logic done;
    logic r;
    done = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      r = (which == 0) ? rdy0 : rdy1;
      if (r === 1'b1) begin
        done = 1'b1;
        if (which == 0) en0 = chain;
        else en1 = chain;
      end else begin
        if (which == 0) en0 = (n == p1 || n == p2);
        else en1 = (n == p1 || n == p2);
        if (which == 0 && n == kc) key0 = 24'h5A5A5A;
      end
    end
    en0 = en0 & done & chain & (which == 0);
    en1 = en1 & done & chain & (which == 1);
  endtask

  task automatic check_s(input int which, input string tag);
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("%s_s%0d", tag, k),
          {24'h0, (which == 0) ? mem0[k] : mem1[k]}, {24'h0, ms[k]});
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] hand_a [6];
  logic [15:0] hand_b [4];
  logic [15:0] hand_c [4];
  int          n;
  int          base;

  initial begin
    hand_a = '{16'h0000, 16'h0000, 16'h0104, 16'h0401, 16'h0242, 16'h4202};
    hand_b = '{16'h00FF, 16'hFF00, 16'h0100, 16'hFF01};
    hand_c = '{16'h0001, 16'h0100, 16'h0102, 16'h0200};
    init0 = 1'b0;
    init1 = 1'b0;
    key0  = 24'h0;
    key1  = 8'h0;
    rst0  = 1'b1;
    en0   = 1'b1;
    rst1  = 1'b1;
    en1   = 1'b1;

    // Reset held two cycles with en high: stays idle.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst_rdy0_%0d", c), {31'h0, rdy0}, 32'd1);
      chk($sformatf("rst_wren0_%0d", c), {31'h0, wren0}, 32'd0);
      chk($sformatf("rst_addr0_%0d", c), {24'h0, addr0}, 32'd0);
      chk($sformatf("rst_wrdata0_%0d", c), {24'h0, wrdata0}, 32'd0);
      chk($sformatf("rst_rdy1_%0d", c), {31'h0, rdy1}, 32'd1);
      chk($sformatf("rst_wren1_%0d", c), {31'h0, wren1}, 32'd0);
    end
    rst0 = 1'b0;
    en0  = 1'b0;
    rst1 = 1'b0;
    en1  = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy0", {31'h0, rdy0}, 32'd1);
    chk("post_rst_wren0", {31'h0, wren0}, 32'd0);
    chk("post_rst_rdy1", {31'h0, rdy1}, 32'd1);

    // Key 00033C over identity S.
    key0 = 24'h00033C;
    mem_init(0);
    model_init();
    model_run({40'h0, key0}, 3, 0);
    base = log0.size();
    start(0, "k33c");
    run_wait(0, 0, 0, 0, 1'b0, n);
    chk("k33c_busy", n, 32'd1537);
    chk("k33c_qempty", exp_q0.size(), 32'd0);
    for (int k = 0; k < 6; k++)
      chk($sformatf("k33c_hand%0d", k), {16'h0, log0[base + k]}, {16'h0, hand_a[k]});
    check_s(0, "k33c");

    // Key FFFFFF, then a back-to-back run with en held in the first rdy cycle.
    key0 = 24'hFFFFFF;
    mem_init(0);
    model_init();
    model_run({40'h0, key0}, 3, 0);
    base = log0.size();
    start(0, "kff");
    run_wait(0, 0, 0, 0, 1'b1, n);
    chk("kff_busy", n, 32'd1537);
    chk("kff_qempty", exp_q0.size(), 32'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("kff_hand%0d", k), {16'h0, log0[base + k]}, {16'h0, hand_b[k]});
    check_s(0, "kff");
    model_run({40'h0, 24'hFFFFFF}, 3, 0);
    run_wait(0, 0, 0, 0, 1'b0, n);
    chk("b2b_busy", n, 32'd1537);
    chk("b2b_qempty", exp_q0.size(), 32'd0);
    check_s(0, "b2b");

    // en pulses while busy and a key change mid-run are ignored.
    key0 = 24'h00033C;
    mem_init(0);
    model_init();
    model_run({40'h0, 24'h00033C}, 3, 0);
    start(0, "hs");
    run_wait(0, 100, 500, 300, 1'b0, n);
    chk("hs_busy", n, 32'd1537);
    chk("hs_qempty", exp_q0.size(), 32'd0);
    check_s(0, "hs");

    // Reset in the WR_I cycle of iteration 40 (cycle 6*40+5 after accept).
    key0 = 24'h00033C;
    mem_init(0);
    model_init();
    model_run({40'h0, key0}, 3, 0);
    start(0, "rmid");
    for (int c = 1; c <= 245; c++) begin
      @(negedge clk);
      en0 = 1'b0;
    end
    chk("rmid_wri_wren", {31'h0, wren0}, 32'd1);
    chk("rmid_wri_addr", {24'h0, addr0}, 32'd40);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("rmid_rdy", {31'h0, rdy0}, 32'd1);
    chk("rmid_wren", {31'h0, wren0}, 32'd0);
    chk("rmid_addr", {24'h0, addr0}, 32'd0);
    chk("rmid_wrdata", {24'h0, wrdata0}, 32'd0);
    chk("rmid_writes_left", exp_q0.size(), 32'd431);
    exp_q0.delete();
    @(negedge clk);
    chk("rmid_idle_wren", {31'h0, wren0}, 32'd0);
    chk("rmid_idle_rdy", {31'h0, rdy0}, 32'd1);
    mem_init(0);
    model_init();
    model_run({40'h0, key0}, 3, 0);
    start(0, "rfresh");
    run_wait(0, 0, 0, 0, 1'b0, n);
    chk("rfresh_busy", n, 32'd1537);
    chk("rfresh_qempty", exp_q0.size(), 32'd0);
    check_s(0, "rfresh");

    // KEYLEN = 1, key 01.
    key1 = 8'h01;
    mem_init(1);
    model_init();
    model_run({56'h0, key1}, 1, 1);
    base = log1.size();
    start(1, "k1");
    run_wait(1, 0, 0, 0, 1'b0, n);
    chk("k1_busy", n, 32'd1537);
    chk("k1_qempty", exp_q1.size(), 32'd0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("k1_hand%0d", k), {16'h0, log1[base + k]}, {16'h0, hand_c[k]});
    check_s(1, "k1");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
